// File: rtl/ram_wishbone_ws_if.sv
// ram_wishbone_ws_if: classic Wishbone slave bus bundle for ram_wishbone_ws.
interface ram_wishbone_ws_if #(parameter int ADDR_WIDTH = 32);
  logic                  CYC_I;
  logic                  STB_I;
  logic                  WE_I;
  logic [3:0]            SEL_I;
  logic [ADDR_WIDTH-1:0] ADR_I;
  logic [31:0]           DAT_I;
  logic [31:0]           DAT_O;
  logic                  ACK_O;
  logic                  ERR_O;
  modport slave (input CYC_I, STB_I, WE_I, SEL_I, ADR_I, DAT_I, output DAT_O, ACK_O, ERR_O);
  modport master (output CYC_I, STB_I, WE_I, SEL_I, ADR_I, DAT_I, input DAT_O, ACK_O, ERR_O);
endinterface

// File: rtl/ram_wishbone_ws.sv
// ram_wishbone_ws: Wishbone data RAM with byte lanes, registered read and wait states.
// Define RAM_WB_BOUNDS_CHECK_EN to answer out-of-range/misaligned accesses with ERR_O.
module ram_wishbone_ws #(
  parameter int SIZE        = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input logic CLK_I,
  input logic RST_N_I,
  ram_wishbone_ws_if.slave bus
);
  localparam int AW = $clog2(SIZE);
  localparam int WORDS = SIZE / 4;
  localparam logic [3:0] WL = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [31:0]           dat_q;
  logic [31:0]           rdata;
  logic                  ack;
  logic                  err;
  logic [31:0]           mem [WORDS];
  logic                  req;
  logic                  go;
  logic                  a_we;
  logic                  a_err;
  logic                  unused_adr;
  logic [3:0]            a_sel;
  logic [ADDR_WIDTH-1:0] a_adr;
  logic [31:0]           a_dat;
  logic [AW-3:0]         idx;
  // In IDLE the live bus is used so a zero-wait access can commit on its accept edge.
  always_comb begin
    req = bus.CYC_I & bus.STB_I;
    a_adr = state == IDLE ? bus.ADR_I : adr_q;
    a_dat = state == IDLE ? bus.DAT_I : dat_q;
    a_sel = state == IDLE ? bus.SEL_I : sel_q;
    a_we = state == IDLE ? bus.WE_I : we_q;
    idx = a_adr[AW-1:2];
    unused_adr = ^a_adr;
    go = RST_N_I & (state == IDLE ? req & (WAIT_STATES == 0) : state == WAIT & bus.CYC_I & cnt == WL);
`ifdef RAM_WB_BOUNDS_CHECK_EN
    a_err = (a_adr >= ADDR_WIDTH'(SIZE)) | (a_adr[1:0] != 2'b00);
`else
    a_err = 1'b0;
`endif
  end
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      rdata <= '0;
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= go & !a_err;
      err <= go & a_err;
      if (go & !a_we & !a_err) rdata <= mem[idx];
      unique case (state)
        IDLE: if (req) begin
          adr_q <= bus.ADR_I;
          dat_q <= bus.DAT_I;
          sel_q <= bus.SEL_I;
          we_q <= bus.WE_I;
          cnt <= '0;
          state <= WAIT_STATES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          state <= !bus.CYC_I ? IDLE : go ? RESP : WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK_I)
    if (go & a_we & !a_err)
      for (int n = 0; n < 4; n++)
        if (a_sel[n]) mem[idx][8*n+:8] <= a_dat[8*n+:8];
  assign bus.DAT_O = rdata;
  assign bus.ACK_O = ack;
  assign bus.ERR_O = err;
endmodule
